vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Consumes the divided pixel tick from clock_divider and produces VGA raster timing.
//  Outputs: hsync/vsync, visible flag, current pixel x/y, line/frame start pulses.
//  Advances one pixel per rising edge of pixel_tick, all in the single clk domain.
//  Sits between the divider and the GPU pixel fetch/output stage.
// PARAMETERS
//  H_VISIBLE    640  visible pixels per line
//  H_FRONT      16   horizontal front porch, in pixels
//  H_SYNC       96   hsync pulse width, in pixels
//  H_BACK       48   horizontal back porch, in pixels
//  V_VISIBLE    480  visible lines per frame
//  V_FRONT      10   vertical front porch, in lines
//  V_SYNC       2    vsync pulse width, in lines
//  V_BACK       33   vertical back porch, in lines
//  HSYNC_ACTIVE 0    hsync level while asserted
//  VSYNC_ACTIVE 0    vsync level while asserted
//  COUNT_WIDTH  10   width of h/v counters and x/y; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
//  clk          in   1            system clock
//  rst          in   1            synchronous reset, active low
//  pixel_tick   in   1            divided clock level (toggling); rising edge = 1 pixel
//  hsync        out  1            horizontal sync, polarity set by HSYNC_ACTIVE
//  vsync        out  1            vertical sync, polarity set by VSYNC_ACTIVE
//  visible      out  1            1 while the current pixel is in the visible area
//  x            out  COUNT_WIDTH  horizontal position of the current pixel, 0..H_TOTAL-1
//  y            out  COUNT_WIDTH  vertical position of the current pixel, 0..V_TOTAL-1
//  line_start   out  1            1-clk pulse when the pixel at x==0 is issued
//  frame_start  out  1            1-clk pulse when the pixel at x==0,y==0 is issued
// BEHAVIOUR
//  Totals: H_TOTAL = sum of the four H_* parameters (800); V_TOTAL = sum of the four V_* (525).
//  Edge detect: tick_d <= pixel_tick every clk; pix_en = pixel_tick & ~tick_d.
//  Reset (rst==0 at posedge clk) values:
//    - h=v=0, x=y=0, visible=0.
//    - hsync=~HSYNC_ACTIVE, vsync=~VSYNC_ACTIVE.
//    - line_start=frame_start=0, tick_d=1 (tick already high at release is not an edge).
//    - Reset mid-frame aborts immediately; no partial-line recovery.
//  On a clk edge with pix_en=1, all outputs latch from the current (h,v):
//    - x<=h, y<=v.
//    - visible <= (h<H_VISIBLE) && (v<V_VISIBLE).
//    - hsync asserted iff H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC.
//    - vsync asserted iff V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC.
//    - line_start <= (h==0); frame_start <= (h==0 && v==0).
//  Counter advance on that same edge:
//    - h<=h+1.
//    - If h==H_TOTAL-1: h<=0 and v<=v+1.
//    - If additionally v==V_TOTAL-1: v<=0.
//  On clk edges with pix_en=0:
//    - line_start and frame_start return to 0 (exactly 1 clk wide).
//    - All other outputs and the counters hold.
//  Latency: outputs change on the clk edge after pixel_tick is first sampled high.
//  pixel_tick held constant (any level): timing freezes, no pulses; resumes on the next rising edge.
//  Decode uses the full-width compare of h and v; there are no other states beyond the h/v counters.
// TESTING
//  1 Release rst, tick low; first rising tick -> next clk: x=0,y=0,visible=1,frame_start=1 and line_start=1 for 1 clk.
//  2 Run one line -> hsync==HSYNC_ACTIVE for exactly 96 pix_en (x 656..751); visible 0 for x>=640.
//  3 At x=799 the next pix_en -> x=0, y+1, line_start pulse; at y=524,x=799 -> x=0,y=0, frame_start pulse.
//  4 Full frame -> vsync active only on y=490,491; exactly 525 line_start and 1 frame_start per 420000 pix_en.
//  5 Hold pixel_tick high 50 clks mid-line -> x/y/syncs frozen, no pulses; advance resumes on next rising edge.
//  6 Assert rst at x=300,y=100 with tick high at release -> next clk all outputs at reset values; no advance until a new rising edge.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (sync, visible, x/y, line/frame pulses)
// advanced one pixel per rising edge of the divided pixel_tick level.
module vga_timing_gen #(
  parameter int   H_VISIBLE    = 640,
  parameter int   H_FRONT      = 16,
  parameter int   H_SYNC       = 96,
  parameter int   H_BACK       = 48,
  parameter int   V_VISIBLE    = 480,
  parameter int   V_FRONT      = 10,
  parameter int   V_SYNC       = 2,
  parameter int   V_BACK       = 33,
  parameter logic HSYNC_ACTIVE = 1'b0,
  parameter logic VSYNC_ACTIVE = 1'b0,
  parameter int   COUNT_WIDTH  = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pixel_tick,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   visible,
  output logic [COUNT_WIDTH-1:0] x,
  output logic [COUNT_WIDTH-1:0] y,
  output logic                   line_start,
  output logic                   frame_start
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [COUNT_WIDTH-1:0] H_VIS  = COUNT_WIDTH'(H_VISIBLE);
  localparam logic [COUNT_WIDTH-1:0] H_SB   = COUNT_WIDTH'(H_VISIBLE + H_FRONT);
  localparam logic [COUNT_WIDTH-1:0] H_SE   = COUNT_WIDTH'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [COUNT_WIDTH-1:0] H_LAST = COUNT_WIDTH'(H_TOTAL - 1);
  localparam logic [COUNT_WIDTH-1:0] V_VIS  = COUNT_WIDTH'(V_VISIBLE);
  localparam logic [COUNT_WIDTH-1:0] V_SB   = COUNT_WIDTH'(V_VISIBLE + V_FRONT);
  localparam logic [COUNT_WIDTH-1:0] V_SE   = COUNT_WIDTH'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [COUNT_WIDTH-1:0] V_LAST = COUNT_WIDTH'(V_TOTAL - 1);
  logic                   tick_q, pix_en, h_last, v_last;
  logic [COUNT_WIDTH-1:0] h_q, h_d, v_q, v_d, x_d, y_d;
  logic                   hsync_d, vsync_d, visible_d, line_start_d, frame_start_d;
  always_comb begin
    pix_en        = pixel_tick & ~tick_q;
    h_last        = h_q == H_LAST;
    v_last        = v_q == V_LAST;
    h_d           = pix_en ? (h_last ? '0 : h_q + 1'b1) : h_q;
    v_d           = (pix_en && h_last) ? (v_last ? '0 : v_q + 1'b1) : v_q;
    x_d           = pix_en ? h_q : x;
    y_d           = pix_en ? v_q : y;
    visible_d     = pix_en ? (h_q < H_VIS && v_q < V_VIS) : visible;
    hsync_d       = pix_en ? ((h_q >= H_SB && h_q < H_SE) ? HSYNC_ACTIVE : ~HSYNC_ACTIVE) : hsync;
    vsync_d       = pix_en ? ((v_q >= V_SB && v_q < V_SE) ? VSYNC_ACTIVE : ~VSYNC_ACTIVE) : vsync;
    line_start_d  = pix_en && h_q == '0;
    frame_start_d = pix_en && h_q == '0 && v_q == '0;
  end
  // tick_q resets high so a tick already high at release is not an edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_q      <= 1'b1;
      h_q         <= '0;
      v_q         <= '0;
      x           <= '0;
      y           <= '0;
      visible     <= 1'b0;
      hsync       <= ~HSYNC_ACTIVE;
      vsync       <= ~VSYNC_ACTIVE;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      tick_q      <= pixel_tick;
      h_q         <= h_d;
      v_q         <= v_d;
      x           <= x_d;
      y           <= y_d;
      visible     <= visible_d;
      hsync       <= hsync_d;
      vsync       <= vsync_d;
      line_start  <= line_start_d;
      frame_start <= frame_start_d;
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized tick cadence against a pixel-count reference model,
// on a default 640x480 instance and a tiny-raster instance for frame wraps.
module tb_vga_timing_gen;
  logic clk = 1'b0, rst, pixel_tick;
  logic hs_d, vs_d, vis_d, ls_d, fs_d, hs_s, vs_s, vis_s, ls_s, fs_s;
  logic [9:0] x_d, y_d, x_s, y_s;
  int checks = 0, passed = 0, n = -1, hs_cnt = 0, ls_cnt = 0, fs_cnt = 0, npix;
  logic prev = 1'b1, p = 1'b0;
  always #5 clk = ~clk;
  vga_timing_gen dut (
    .clk(clk), .rst(rst), .pixel_tick(pixel_tick), .hsync(hs_d), .vsync(vs_d),
    .visible(vis_d), .x(x_d), .y(y_d), .line_start(ls_d), .frame_start(fs_d)
  );
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
  ) dut_s (
    .clk(clk), .rst(rst), .pixel_tick(pixel_tick), .hsync(hs_s), .vsync(vs_s),
    .visible(vis_s), .x(x_s), .y(y_s), .line_start(ls_s), .frame_start(fs_s)
  );
  // n is the index of the most recently issued pixel since reset (-1: none)
  function automatic logic [24:0] expv(int k, logic pulse, int hv, int hf, int hs, int hb,
                                       int vv, int vf, int vs, int vb);
    int ht, vt, h, v;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    if (k < 0) return {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 2'b00};
    h = k % ht;
    v = (k / ht) % vt;
    return {!(h >= hv + hf && h < hv + hf + hs), !(v >= vv + vf && v < vv + vf + vs),
            (h < hv && v < vv), 10'(h), 10'(v), (pulse && h == 0), (pulse && h == 0 && v == 0)};
  endfunction
  task automatic chk(input string tag, input logic [24:0] got, input logic [24:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s at %0t: observed=%h expected=%h", tag, $time, got, exp);
  endtask
  task automatic step(input logic t);
    pixel_tick = t;
    @(posedge clk);
    #1;
    if (!rst) begin
      n = -1; prev = 1'b1; p = 1'b0;
    end else begin
      p = t && !prev;
      if (p) n++;
      prev = t;
    end
    chk("dflt", {hs_d, vs_d, vis_d, x_d, y_d, ls_d, fs_d}, expv(n, p, 640, 16, 96, 48, 480, 10, 2, 33));
    chk("small", {hs_s, vs_s, vis_s, x_s, y_s, ls_s, fs_s}, expv(n, p, 8, 2, 3, 2, 4, 1, 2, 2));
    if (rst) begin
      ls_cnt += int'(ls_s);
      fs_cnt += int'(fs_s);
      if (p && n < 800 && !hs_d) hs_cnt++;
    end
  endtask
  initial begin
    rst = 1'b0;
    pixel_tick = 1'b0;
    repeat (3) step(1'b0);
    rst = 1'b1;
    step(1'b0);
    for (int i = 0; i < 1700; i++) begin
      int hi;
      hi = (i == 300) ? 50 : int'($urandom_range(1, 3));
      repeat ($urandom_range(1, 3)) step(1'b0);
      repeat (hi) step(1'b1);
    end
    npix = n + 1;
    chk("hsync_width", 25'(hs_cnt), 25'(96));
    chk("line_starts", 25'(ls_cnt), 25'((npix + 14) / 15));
    chk("frame_starts", 25'(fs_cnt), 25'((npix + 134) / 135));
    step(1'b0);
    rst = 1'b0;
    repeat (3) step(1'b1);
    rst = 1'b1;
    repeat (5) step(1'b1);
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(1, 3)) step(1'b0);
      repeat ($urandom_range(1, 3)) step(1'b1);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
